// File: rtl/signed_lin_calc_seq_pkg.sv
// Shared types, constants and helpers for the serial signed linear calculator.
// Optional feature macro: SIGNED_CALC_SAT_EN (saturate o_fs on overflow).
package signed_calc_pkg;

    // FSM state encoding
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_MUL  = 2'd1;
    localparam state_t ST_OUT  = 2'd2;
    localparam state_t ST_HOLD = 2'd3;

    // Default coefficients of the original fixed 7X-3Y+6Z calculator
    localparam int DEF_K0 = 7;
    localparam int DEF_K1 = -3;
    localparam int DEF_K2 = 6;

    // Wide signed carrier used by the output-stage helpers
    localparam int unsigned MAX_AW = 64;
    typedef logic signed [MAX_AW-1:0] wide_t;

    // Accumulator width that holds any result without overflow
    function automatic int unsigned acc_width(input int unsigned w, input int unsigned cw);
        return w + cw + 2;
    endfunction

    // True when v is representable in ow signed bits
    function automatic logic fits_signed(input wide_t v, input int unsigned ow);
        wide_t hi;
        wide_t lo;
        hi = (wide_t'(1) <<< (ow - 1)) - wide_t'(1);
        lo = ~hi;
        return (v <= hi) && (v >= lo);
    endfunction

    // Output-stage conversion; caller keeps the low ow bits
    function automatic wide_t sat_trunc(input wide_t acc, input int unsigned ow);
        wide_t hi;
        wide_t lo;
        hi = (wide_t'(1) <<< (ow - 1)) - wide_t'(1);
        lo = ~hi;
`ifdef SIGNED_CALC_SAT_EN
        if (acc > hi) begin
            return hi;
        end else if (acc < lo) begin
            return lo;
        end
        return acc;
`else
        return acc & (hi | (wide_t'(1) <<< (ow - 1)));
`endif
    endfunction

endpackage

// File: rtl/signed_lin_calc_seq_if.sv
// Operand/result handshake bundle for signed_lin_calc_seq.
interface signed_lin_calc_seq_if #(
    parameter int unsigned W  = 4,
    parameter int unsigned OW = 8
);
    logic                 i_valid;
    logic                 o_ready;
    logic signed [W-1:0]  i_as;
    logic signed [W-1:0]  i_bs;
    logic signed [W-1:0]  i_cs;
    logic                 o_valid;
    logic                 i_ready;
    logic signed [OW-1:0] o_fs;
    logic                 o_ovf;

    // Calculator side
    modport slave (
        input  i_valid, i_as, i_bs, i_cs, i_ready,
        output o_ready, o_valid, o_fs, o_ovf
    );

    // Source/sink side
    modport master (
        output i_valid, i_as, i_bs, i_cs, i_ready,
        input  o_ready, o_valid, o_fs, o_ovf
    );
endinterface

// File: rtl/signed_lin_calc_seq_serial_term_sel.sv
// Per-cycle partial product: sum of operands whose coefficient bit i is set,
// shifted by i, negated on the coefficient sign bit.
module serial_term_sel #(
    parameter int unsigned   AW   = 10,
    parameter int unsigned   CW   = 4,
    parameter int unsigned   IW   = 2,
    parameter logic [CW-1:0] K0_B = '0,
    parameter logic [CW-1:0] K1_B = '0,
    parameter logic [CW-1:0] K2_B = '0
) (
    input  logic [IW-1:0]        i_idx,
    input  logic signed [AW-1:0] i_a,
    input  logic signed [AW-1:0] i_b,
    input  logic signed [AW-1:0] i_c,
    output logic signed [AW-1:0] o_term_c
);
    logic signed [AW-1:0] w_sum;

    // Select and sum shifted operands, subtract on the sign bit
    always_comb begin
        w_sum = '0;
        if (K0_B[i_idx]) w_sum = w_sum + (i_a <<< i_idx);
        if (K1_B[i_idx]) w_sum = w_sum + (i_b <<< i_idx);
        if (K2_B[i_idx]) w_sum = w_sum + (i_c <<< i_idx);
        o_term_c = (i_idx == IW'(CW - 1)) ? -w_sum : w_sum;
    end
endmodule

// File: rtl/signed_lin_calc_seq.sv
// Serial shift-add evaluator of F = K0*A + K1*B + K2*C with valid/ready handshakes.
// Optional feature macro: SIGNED_CALC_SAT_EN (saturate o_fs on overflow).
module signed_lin_calc_seq
    import signed_calc_pkg::*;
#(
    parameter int unsigned W  = 4,
    parameter int unsigned CW = 4,
    parameter int          K0 = DEF_K0,
    parameter int          K1 = DEF_K1,
    parameter int          K2 = DEF_K2,
    parameter int unsigned OW = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    signed_lin_calc_seq_if.slave   bus
);
    localparam int unsigned   AW       = acc_width(W, CW);
    localparam int unsigned   IW       = (CW > 1) ? $clog2(CW) : 1;
    localparam logic [CW-1:0] K0_B     = CW'(K0);
    localparam logic [CW-1:0] K1_B     = CW'(K1);
    localparam logic [CW-1:0] K2_B     = CW'(K2);
    localparam logic [IW-1:0] IDX_LAST = IW'(CW - 1);

    state_t               r_state, w_state_nxt;
    logic signed [AW-1:0] r_a, r_b, r_c, r_acc;
    logic signed [AW-1:0] w_a_nxt, w_b_nxt, w_c_nxt, w_acc_nxt;
    logic [IW-1:0]        r_idx, w_idx_nxt;
    logic                 r_ready, w_ready_nxt;
    logic                 r_valid, w_valid_nxt;
    logic [OW-1:0]        r_fs, w_fs_nxt;
    logic                 r_ovf, w_ovf_nxt;
    logic signed [AW-1:0] w_term_c;
    wide_t                w_acc_wide;

    serial_term_sel #(
        .AW   (AW),
        .CW   (CW),
        .IW   (IW),
        .K0_B (K0_B),
        .K1_B (K1_B),
        .K2_B (K2_B)
    ) u_term (
        .i_idx    (r_idx),
        .i_a      (r_a),
        .i_b      (r_b),
        .i_c      (r_c),
        .o_term_c (w_term_c)
    );

    assign w_acc_wide = wide_t'(r_acc);

    // Next-state, datapath and output-register values
    always_comb begin
        w_state_nxt = r_state;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_c_nxt     = r_c;
        w_acc_nxt   = r_acc;
        w_idx_nxt   = r_idx;
        w_ready_nxt = r_ready;
        w_valid_nxt = r_valid;
        w_fs_nxt    = r_fs;
        w_ovf_nxt   = r_ovf;
        case (r_state)
            ST_IDLE: begin
                if (bus.i_valid) begin
                    w_a_nxt     = $signed({{(AW - W){bus.i_as[W-1]}}, bus.i_as});
                    w_b_nxt     = $signed({{(AW - W){bus.i_bs[W-1]}}, bus.i_bs});
                    w_c_nxt     = $signed({{(AW - W){bus.i_cs[W-1]}}, bus.i_cs});
                    w_acc_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_ready_nxt = 1'b0;
                    w_state_nxt = ST_MUL;
                end
            end
            ST_MUL: begin
                w_acc_nxt = r_acc + w_term_c;
                w_idx_nxt = r_idx + IW'(1);
                if (r_idx == IDX_LAST) begin
                    w_state_nxt = ST_OUT;
                end
            end
            ST_OUT: begin
                w_fs_nxt    = OW'(sat_trunc(w_acc_wide, OW));
                w_ovf_nxt   = ~fits_signed(w_acc_wide, OW);
                w_valid_nxt = 1'b1;
                w_state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                if (bus.i_ready) begin
                    w_valid_nxt = 1'b0;
                    w_ready_nxt = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_valid_nxt = 1'b0;
                w_ready_nxt = 1'b1;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_c     <= '0;
            r_acc   <= '0;
            r_idx   <= '0;
            r_ready <= 1'b1;
            r_valid <= 1'b0;
            r_fs    <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
            r_c     <= w_c_nxt;
            r_acc   <= w_acc_nxt;
            r_idx   <= w_idx_nxt;
            r_ready <= w_ready_nxt;
            r_valid <= w_valid_nxt;
            r_fs    <= w_fs_nxt;
            r_ovf   <= w_ovf_nxt;
        end
    end

    assign bus.o_ready = r_ready;
    assign bus.o_valid = r_valid;
    assign bus.o_fs    = $signed(r_fs);
    assign bus.o_ovf   = r_ovf;
endmodule

// File: tb/tb_signed_lin_calc_seq.sv
// Directed bench for signed_lin_calc_seq (OW=8 main instance, OW=6 overflow instance).
module tb_signed_lin_calc_seq;
    logic clk;
    logic rst;
    logic t_valid;
    logic t_ready;
    logic signed [3:0] t_a, t_b, t_c;
    int n_cmp;
    int n_fail;

    signed_lin_calc_seq_if #(.W(4), .OW(8)) bus  ();
    signed_lin_calc_seq_if #(.W(4), .OW(6)) bus6 ();

    assign bus.i_valid  = t_valid;
    assign bus.i_ready  = t_ready;
    assign bus.i_as     = t_a;
    assign bus.i_bs     = t_b;
    assign bus.i_cs     = t_c;
    assign bus6.i_valid = t_valid;
    assign bus6.i_ready = t_ready;
    assign bus6.i_as    = t_a;
    assign bus6.i_bs    = t_b;
    assign bus6.i_cs    = t_c;

    signed_lin_calc_seq #(.W(4), .CW(4), .K0(7), .K1(-3), .K2(6), .OW(8)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    signed_lin_calc_seq #(.W(4), .CW(4), .K0(7), .K1(-3), .K2(6), .OW(6)) dut6 (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the block idle; returns at the negedge after the accept edge
    task automatic accept(input logic signed [3:0] a, input logic signed [3:0] b,
                          input logic signed [3:0] c, input string tag);
        t_a = a;
        t_b = b;
        t_c = c;
        t_valid = 1'b1;
        chk({tag, "_rdy"}, 32'(bus.o_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        t_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        bit seen;
        lat = 0;
        seen = 1'b0;
        while (!seen && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (bus.o_valid === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic do_result(input logic signed [3:0] a, input logic signed [3:0] b,
                             input logic signed [3:0] c, input logic [7:0] efs,
                             input logic eovf, input string tag);
        int lat;
        accept(a, b, c, tag);
        wait_valid(lat);
        chk({tag, "_lat"}, 32'(lat), 32'd5);
        chk({tag, "_fs"}, 32'($unsigned(bus.o_fs)), 32'(efs));
        chk({tag, "_ovf"}, 32'(bus.o_ovf), 32'(eovf));
    endtask

    task automatic drain(input string tag);
        t_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        t_ready = 1'b0;
        chk({tag, "_drain_vld"}, 32'(bus.o_valid), 32'd0);
        chk({tag, "_drain_rdy"}, 32'(bus.o_ready), 32'd1);
    endtask

    initial begin
        int lat;
        int seen;
        logic [5:0] e6_pos;
        logic [5:0] e6_neg;
        n_cmp   = 0;
        n_fail  = 0;
        rst     = 1'b1;
        t_valid = 1'b0;
        t_ready = 1'b0;
        t_a = '0;
        t_b = '0;
        t_c = '0;
`ifdef SIGNED_CALC_SAT_EN
        e6_pos = 6'h1F;
        e6_neg = 6'h20;
`else
        e6_pos = 6'h33;
        e6_neg = 6'h03;
`endif
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(bus.o_ready), 32'd1);
        chk("rst_valid", 32'(bus.o_valid), 32'd0);
        chk("rst_fs", 32'($unsigned(bus.o_fs)), 32'h0);
        chk("rst_ovf", 32'(bus.o_ovf), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        do_result(4'sd0, 4'sd0, 4'sd0, 8'h00, 1'b0, "zero");
        drain("zero");
        do_result(-4'sd1, -4'sd1, -4'sd1, 8'hF6, 1'b0, "all_m1");
        drain("all_m1");
        do_result(-4'sd1, 4'sd0, -4'sd1, 8'hF3, 1'b0, "m1_0_m1");
        drain("m1_0_m1");
        do_result(4'sd1, 4'sd2, 4'sd4, 8'h19, 1'b0, "one_two_four");
        drain("one_two_four");

        do_result(4'sd7, -4'sd8, 4'sd7, 8'h73, 1'b0, "ext_pos");
        chk("ext_pos_ow6_ovf", 32'(bus6.o_ovf), 32'd1);
        chk("ext_pos_ow6_fs", 32'($unsigned(bus6.o_fs)), 32'(e6_pos));
        drain("ext_pos");
        do_result(-4'sd8, 4'sd7, -4'sd8, 8'h83, 1'b0, "ext_neg");
        chk("ext_neg_ow6_ovf", 32'(bus6.o_ovf), 32'd1);
        chk("ext_neg_ow6_fs", 32'($unsigned(bus6.o_fs)), 32'(e6_neg));
        drain("ext_neg");

        // Back-pressure with an ignored second operand pulse
        do_result(4'sd1, 4'sd2, 4'sd4, 8'h19, 1'b0, "bp");
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("bp_hold_vld", 32'(bus.o_valid), 32'd1);
            chk("bp_hold_fs", 32'($unsigned(bus.o_fs)), 32'h19);
            chk("bp_hold_rdy", 32'(bus.o_ready), 32'd0);
            if (i == 1) begin
                t_a = 4'sd7;
                t_b = -4'sd8;
                t_c = 4'sd7;
                t_valid = 1'b1;
            end else begin
                t_valid = 1'b0;
            end
        end
        drain("bp");
        do_result(-4'sd1, 4'sd0, -4'sd1, 8'hF3, 1'b0, "bp_next");
        drain("bp_next");

        // Reset in the middle of MUL
        accept(4'sd7, -4'sd8, 4'sd7, "mid_rst");
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_ready", 32'(bus.o_ready), 32'd1);
        chk("mid_rst_valid", 32'(bus.o_valid), 32'd0);
        chk("mid_rst_fs", 32'($unsigned(bus.o_fs)), 32'h0);
        chk("mid_rst_ovf", 32'(bus.o_ovf), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.o_valid !== 1'b0) seen++;
        end
        chk("mid_rst_no_valid", 32'(seen), 32'd0);
        do_result(-4'sd1, -4'sd1, -4'sd1, 8'hF6, 1'b0, "post_rst");
        drain("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
